fifo_drain: RTL and testbench

Read-side stage placed directly downstream of the team's synchronous FIFO.
- Drives the FIFO's `rd_en` from its `empty` flag and captures `dout` one cycle after each successful pop.
- Re-presents the captured words on a valid/ready stream.
- Holds data in a small output buffer so that `out_ready` has no combinational path to `fifo_rd_en`, while sustaining one word per cycle.
- Also provides a synchronous flush and a beat counter for the verification scoreboard.

---
 rtl/fifo_drain_pkg.sv | 13 +
 rtl/drain_ring_buf.sv | 56 +++++
 rtl/fifo_drain.sv | 63 ++++++
 tb/tb_fifo_drain.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared constants and sizing helpers for the FIFO read-side drain stage.
package fifo_drain_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_BUF_DEPTH = 3;
    localparam int unsigned DEF_CNT_W     = 16;

    // Bits needed to hold a count from 0 to depth inclusive.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/drain_ring_buf.sv
// Circular buffer with push/pop/clear; indices wrap at DEPTH (any value >= 2).
module drain_ring_buf
    import fifo_drain_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_BUF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [occ_w(DEPTH)-1:0]   count,
    output logic [WIDTH-1:0]          head_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = occ_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign head_data = mem[rd_idx];

    // Clear drops a same-cycle push; the caller never pops an empty buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else if (clear) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= wrap_inc(wr_idx);
            end
            if (pop) begin
                rd_idx <= wrap_inc(rd_idx);
            end
            count <= count + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// Read-side stage for the synchronous FIFO: pops into a small ring buffer and
// re-presents words on valid/ready with no ready-to-rd_en combinational path.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    input  logic [WIDTH-1:0]              fifo_dout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          flush,
    output logic [occ_w(BUF_DEPTH)-1:0]   occupancy,
    output logic [CNT_W-1:0]              beat_cnt
);

    localparam int unsigned OCC_W = occ_w(BUF_DEPTH);
    localparam int unsigned SUM_W = OCC_W + 1;

    logic             inflight;
    logic             xfer;
    logic [SUM_W-1:0] pending;

    // Reserve a slot for the word already in flight before popping again.
    assign pending    = SUM_W'(occupancy) + SUM_W'(inflight);
    assign fifo_rd_en = !fifo_empty && !flush && (pending < SUM_W'(BUF_DEPTH));
    assign out_valid  = (occupancy != '0);
    assign xfer       = out_valid && out_ready;

    drain_ring_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (xfer),
        .count     (occupancy),
        .head_data (out_data)
    );

    // Flush forces rd_en low, so inflight clears without a special case.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: queue-based stream model checked every cycle,
// plus literal expectations per scenario.
module tb_fifo_drain;
    import fifo_drain_pkg::*;

    localparam int unsigned W   = DEF_WIDTH;
    localparam int unsigned OW3 = occ_w(3);
    localparam int unsigned OW2 = occ_w(2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, out_ready;
    logic fe [2];
    logic [W-1:0] fd [2];

    logic           rd_a, vld_a, rd_w, vld_w, rd_d, vld_d;
    logic [W-1:0]   dat_a, dat_w, dat_d;
    logic [OW3-1:0] occ_a, occ_x;
    logic [OW2-1:0] occ_d;
    logic [15:0]    beat_a, beat_d;
    logic [3:0]     beat_w;

    fifo_drain #(.WIDTH(W), .BUF_DEPTH(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe[0]), .fifo_rd_en(rd_a), .fifo_dout(fd[0]),
        .out_valid(vld_a), .out_ready(out_ready), .out_data(dat_a), .flush(flush),
        .occupancy(occ_a), .beat_cnt(beat_a));

    fifo_drain #(.WIDTH(W), .BUF_DEPTH(3), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe[0]), .fifo_rd_en(rd_w), .fifo_dout(fd[0]),
        .out_valid(vld_w), .out_ready(out_ready), .out_data(dat_w), .flush(flush),
        .occupancy(occ_x), .beat_cnt(beat_w));

    fifo_drain #(.WIDTH(W), .BUF_DEPTH(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe[1]), .fifo_rd_en(rd_d), .fifo_dout(fd[1]),
        .out_valid(vld_d), .out_ready(out_ready), .out_data(dat_d), .flush(flush),
        .occupancy(occ_d), .beat_cnt(beat_d));

    // Model: upstream FIFO contents, buffered words, in-flight flag, beat count.
    logic [W-1:0] fq  [2][$];
    logic [W-1:0] mq  [2][$];
    bit           minf  [2];
    int unsigned  mbeat [2];
    logic [W-1:0] obs [2][$];
    int           obs_cyc [2][$];

    bit           pe_rst, pe_fl, pe_rdy;
    bit           pe_rd   [2];
    logic [W-1:0] pe_dout [2];

    int total = 0, bad = 0, cyc = 0;
    bit chk_en = 0, trk = 0;
    int first_rd, first_vld, nrd, maxocc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    function automatic bit exp_rd(input int k);
        return (fq[k].size() != 0) && !flush && ((mq[k].size() + int'(minf[k])) < dep(k));
    endfunction

    task automatic compare_all();
        chk("a.rd_en", rd_a, exp_rd(0));
        chk("a.valid", vld_a, mq[0].size() != 0);
        if (mq[0].size() != 0) chk("a.data", dat_a, mq[0][0]);
        chk("a.occ", occ_a, mq[0].size());
        chk("a.beat", beat_a, mbeat[0] & 32'hFFFF);
        chk("w.rd_en", rd_w, exp_rd(0));
        chk("w.valid", vld_w, mq[0].size() != 0);
        if (mq[0].size() != 0) chk("w.data", dat_w, mq[0][0]);
        chk("w.occ", occ_x, mq[0].size());
        chk("w.beat", beat_w, mbeat[0] & 32'hF);
        chk("d2.rd_en", rd_d, exp_rd(1));
        chk("d2.valid", vld_d, mq[1].size() != 0);
        if (mq[1].size() != 0) chk("d2.data", dat_d, mq[1][0]);
        chk("d2.occ", occ_d, mq[1].size());
        chk("d2.beat", beat_d, mbeat[1] & 32'hFFFF);
        if (rst_n && out_ready && vld_a) begin obs[0].push_back(dat_a); obs_cyc[0].push_back(cyc); end
        if (rst_n && out_ready && vld_d) begin obs[1].push_back(dat_d); obs_cyc[1].push_back(cyc); end
        if (trk) begin
            if (rd_a && first_rd < 0) first_rd = cyc;
            if (vld_a && first_vld < 0) first_vld = cyc;
            if (rd_a) nrd++;
            if (int'(occ_a) > maxocc) maxocc = int'(occ_a);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (!pe_rst) begin
                mq[k].delete();
                minf[k]  = 0;
                mbeat[k] = 0;
                fd[k]    = '0;
                fe[k]    = (fq[k].size() == 0);
                continue;
            end
            if (mq[k].size() != 0 && pe_rdy) begin
                void'(mq[k].pop_front());
                mbeat[k]++;
            end
            if (minf[k] && !pe_fl) mq[k].push_back(pe_dout[k]);
            if (pe_fl) mq[k].delete();
            minf[k] = pe_rd[k];
            if (pe_rd[k]) fd[k] = fq[k].pop_front();
            else          fd[k] = W'($urandom);
            fe[k] = (fq[k].size() == 0);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) compare_all();
        pe_rst = rst_n; pe_fl = flush; pe_rdy = out_ready;
        for (int k = 0; k < 2; k++) begin
            pe_rd[k]   = exp_rd(k);
            pe_dout[k] = fd[k];
        end
        @(posedge clk);
        #1;
        model_update();
        cyc++;
        #1;
    endtask

    task automatic push(input int k, input logic [W-1:0] d);
        fq[k].push_back(d);
        fe[k] = 1'b0;
    endtask

    task automatic drain_until(input int k, input int target, input int budget, input string name);
        int n = 0;
        while (obs[k].size() < target && n < budget) begin cycle(); n++; end
        chk(name, obs[k].size() >= target, 1);
    endtask

    initial begin
        int base, bbase, n;
        logic [W-1:0] alt [20];

        rst_n = 0; flush = 0; out_ready = 0;
        fe[0] = 1; fe[1] = 1; fd[0] = '0; fd[1] = '0;
        cycle(); cycle();
        chk_en = 1; rst_n = 1;
        chk("rst.rd_en", rd_a, 0);
        chk("rst.valid", vld_a, 0);
        chk("rst.data", dat_a, 0);
        chk("rst.occ", occ_a, 0);
        chk("rst.beat", beat_a, 0);

        // streaming
        trk = 1; first_rd = -1; first_vld = -1;
        for (int i = 1; i <= 8; i++) push(0, W'(i));
        out_ready = 1;
        drain_until(0, 8, 40, "stream.budget");
        trk = 0;
        for (int i = 0; i < 8; i++) chk("stream.data", obs[0][i], i + 1);
        chk("stream.latency", first_vld - first_rd, 2);
        chk("stream.span", obs_cyc[0][7] - obs_cyc[0][0], 7);
        chk("stream.beat", beat_a, 8);

        // backpressure
        out_ready = 0; nrd = 0; trk = 1;
        for (int i = 0; i < 6; i++) push(0, W'(8'h10 + i));
        repeat (10) cycle();
        trk = 0;
        chk("bp.pops", nrd, 3);
        chk("bp.occ", occ_a, 3);
        chk("bp.valid", vld_a, 1);
        chk("bp.head", dat_a, 8'h10);
        out_ready = 1; base = obs[0].size();
        drain_until(0, base + 6, 30, "bp.budget");
        for (int i = 0; i < 6; i++) chk("bp.data", obs[0][base + i], 8'h10 + i);
        chk("bp.span", obs_cyc[0][base + 5] - obs_cyc[0][base], 5);

        // alternating ready
        bbase = int'(beat_a); base = obs[0].size(); maxocc = 0; trk = 1;
        for (int i = 0; i < 20; i++) begin alt[i] = W'($urandom); push(0, alt[i]); end
        n = 0;
        while (obs[0].size() < base + 20 && n < 100) begin
            out_ready = ~out_ready;
            cycle(); n++;
        end
        trk = 0;
        chk("alt.budget", obs[0].size() >= base + 20, 1);
        for (int i = 0; i < 20; i++) chk("alt.data", obs[0][base + i], alt[i]);
        chk("alt.beat", int'(beat_a) - bbase, 20);
        chk("alt.maxocc_le3", maxocc <= 3, 1);

        // flush with a word landing
        out_ready = 0;
        for (int i = 0; i < 5; i++) push(0, W'(8'h21 + i));
        n = 0;
        while (!(mq[0].size() == 2 && minf[0]) && n < 20) begin cycle(); n++; end
        chk("flush.setup", n < 20, 1);
        chk("flush.pre_occ", occ_a, 2);
        bbase = int'(beat_a);
        flush = 1; cycle(); flush = 0;
        chk("flush.occ", occ_a, 0);
        chk("flush.valid", vld_a, 0);
        chk("flush.beat_kept", beat_a, bbase);
        out_ready = 1; base = obs[0].size();
        drain_until(0, base + 2, 20, "flush.budget");
        chk("flush.next", obs[0][base], 8'h24);
        chk("flush.next2", obs[0][base + 1], 8'h25);

        // counter wrap, then reset mid-stream
        rst_n = 0; fq[0].delete(); fe[0] = 1;
        cycle(); rst_n = 1;
        for (int i = 0; i < 22; i++) push(0, W'(8'h40 + i));
        n = 0;
        while (mbeat[0] < 17 && n < 60) begin cycle(); n++; end
        chk("wrap.budget", n < 60, 1);
        chk("wrap.beat4", beat_w, 1);
        chk("wrap.beat16", beat_a, 17);
        rst_n = 0; fq[0].delete(); fe[0] = 1;
        cycle();
        chk("rst2.rd_en", rd_a, 0);
        chk("rst2.valid", vld_a, 0);
        chk("rst2.data", dat_a, 0);
        chk("rst2.occ", occ_a, 0);
        chk("rst2.beat", beat_a, 0);
        chk("rst2.beat4", beat_w, 0);
        rst_n = 1;
        repeat (3) cycle();
        chk("rst2.no_stale", vld_a, 0);
        base = obs[0].size();
        push(0, 8'hA5);
        drain_until(0, base + 1, 10, "rst2.budget");
        chk("rst2.first", obs[0][base], 8'hA5);

        // depth 2
        base = obs[1].size();
        for (int i = 0; i < 12; i++) push(1, W'(8'h60 + i));
        drain_until(1, base + 12, 60, "d2.budget");
        for (int i = 0; i < 12; i++) chk("d2.data", obs[1][base + i], 8'h60 + i);
        chk("d2.below_full_rate", (obs_cyc[1][base + 11] - obs_cyc[1][base] + 1) > 12, 1);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
